// File: rtl/present_arbiter_ctrl.sv
// rtl/present_arbiter_ctrl.sv - round-robin sharing of one PRESENT core between two requesters
module present_arbiter_ctrl #(
  parameter int TIMEOUT   = 127,
  parameter int DONE_MASK = 2
) (
  input  logic        clk,
  input  logic        iReset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_dat,
  input  logic [79:0] req0_key,
  input  logic        req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_dat,
  input  logic [79:0] req1_key,
  input  logic        req1_mode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_dat,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic        core_load,
  output logic        core_control,
  output logic [63:0] core_idat,
  output logic [79:0] core_key,
  input  logic [63:0] core_odat,
  input  logic        core_done
);

  localparam logic [6:0] TIMEOUT_C = 7'(TIMEOUT);
  localparam logic [6:0] MASK_C    = 7'(DONE_MASK);

  typedef enum logic [2:0] {IDLE, GRANT, LOAD, RUN, RESP} state_t;

  state_t      state, state_nxt;
  logic        win_id, win_nxt, win_valid, last_grant;
  logic        done_ok, timed_out;
  logic [63:0] job_dat;
  logic [79:0] job_key;
  logic        job_mode, job_id;
  logic [6:0]  cnt;
  logic        core_load_q;
  logic [63:0] rsp_dat_q;
  logic        rsp_id_q, rsp_err_q;

  assign win_valid = win_id ? req1_valid : req0_valid;
  // cnt is the number of RUN cycles already completed; done in the first DONE_MASK is stale
  assign done_ok   = core_done && (cnt >= MASK_C);
  assign timed_out = (cnt + 7'd1) == TIMEOUT_C;

  assign core_load    = core_load_q;
  assign core_idat    = job_dat;
  assign core_key     = job_key;
  assign core_control = job_mode;
  assign rsp_dat      = rsp_dat_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_err      = rsp_err_q;

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    win_nxt    = win_id;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          win_nxt   = ~last_grant;
          state_nxt = GRANT;
        end else if (req0_valid) begin
          win_nxt   = 1'b0;
          state_nxt = GRANT;
        end else if (req1_valid) begin
          win_nxt   = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // a winner that withdrew before the accept pulse is simply dropped
        req0_ready = win_valid && !win_id;
        req1_ready = win_valid && win_id;
        state_nxt  = win_valid ? LOAD : IDLE;
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (done_ok || timed_out) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      win_id      <= 1'b0;
      last_grant  <= 1'b1;
      core_load_q <= 1'b1;
      job_dat     <= '0;
      job_key     <= '0;
      job_mode    <= 1'b0;
      job_id      <= 1'b0;
      cnt         <= '0;
      rsp_dat_q   <= '0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      win_id      <= win_nxt;
      core_load_q <= (state_nxt == LOAD);
      if (state == GRANT && win_valid) begin
        job_dat  <= win_id ? req1_dat  : req0_dat;
        job_key  <= win_id ? req1_key  : req0_key;
        job_mode <= win_id ? req1_mode : req0_mode;
        job_id   <= win_id;
      end
      if (state == LOAD)     cnt <= '0;
      else if (state == RUN) cnt <= cnt + 7'd1;
      if (state == RUN && done_ok) begin
        rsp_dat_q <= core_odat;
        rsp_err_q <= 1'b0;
        rsp_id_q  <= job_id;
      end else if (state == RUN && timed_out) begin
        rsp_dat_q <= '0;
        rsp_err_q <= 1'b1;
        rsp_id_q  <= job_id;
      end
      if (state == RESP && rsp_ready) last_grant <= job_id;
    end
  end

endmodule

// File: tb/tb_present_arbiter_ctrl.sv
// tb/tb_present_arbiter_ctrl.sv - bench for present_arbiter_ctrl with a stub core and timeline model
module tb_present_arbiter_ctrl;

  localparam int TIMEOUT   = 127;
  localparam int DONE_MASK = 2;
  localparam logic [63:0] DAT_A = 64'h4c746e677579656e;
  localparam logic [79:0] KEY_A = 80'h466574656c48636d7573;
  localparam logic [63:0] RES_A = 64'h0e1d00d4e46ba99c;
  localparam logic [63:0] DAT_B = 64'h9346f086b0b1c9b4;
  localparam logic [79:0] KEY_B = 80'h00000000000000000001;
  localparam logic [63:0] RES_B = 64'h466574656c5f5553;

  typedef struct {
    logic [63:0] d;
    logic [79:0] k;
    logic        m;
  } job_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_dat = '0, req1_dat = '0;
  logic [79:0] req0_key = '0, req1_key = '0;
  logic        req0_mode = 1'b0, req1_mode = 1'b0;
  logic        rsp_valid, rsp_id, rsp_err;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_dat;
  logic        core_load, core_control, core_done;
  logic [63:0] core_idat, core_odat;
  logic [79:0] core_key;
  logic        tie_done = 1'b0;

  always #5 clk = ~clk;

  present_arbiter_ctrl #(.TIMEOUT(TIMEOUT), .DONE_MASK(DONE_MASK)) dut (
    .clk(clk), .iReset(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dat(req0_dat),
    .req0_key(req0_key), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dat(req1_dat),
    .req1_key(req1_key), .req1_mode(req1_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .core_load(core_load), .core_control(core_control), .core_idat(core_idat),
    .core_key(core_key), .core_odat(core_odat), .core_done(core_done)
  );

  // Known PRESENT-80 vectors map to their real results; other jobs get a cheap stand-in.
  function automatic logic [63:0] core_fn(input logic [63:0] d, input logic [79:0] k, input logic m);
    if (!m && d == DAT_A && k == KEY_A) return RES_A;
    if (m && d == DAT_B && k == KEY_B) return RES_B;
    return d ^ k[79:16] ^ {64{m}};
  endfunction

  // Stub core: done stays high from completion until two cycles after the next load.
  logic [63:0] s_dat = '0;
  logic [79:0] s_key = '0;
  logic        s_mode = 1'b0, done_r = 1'b0;
  logic [6:0]  s_cnt = '0;
  logic [1:0]  s_hold = '0;

  always @(posedge clk) begin
    if (core_load) begin
      s_dat  <= core_idat;
      s_key  <= core_key;
      s_mode <= core_control;
      s_cnt  <= core_control ? 7'd64 : 7'd32;
      s_hold <= 2'd2;
    end else if (s_hold != 2'd0) begin
      s_hold <= s_hold - 2'd1;
      if (s_hold == 2'd1) done_r <= 1'b0;
    end else if (s_cnt != 7'd0) begin
      s_cnt <= s_cnt - 7'd1;
      if (s_cnt == 7'd1) done_r <= 1'b1;
    end
  end

  assign core_odat = core_fn(s_dat, s_key, s_mode);
  assign core_done = tie_done ? (s_hold != 2'd0) : done_r;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Model: a timeline of grant cycle, resolution cycle and handshake, rebuilt from the rules.
  int  cyc = 0;
  bit  m_free = 1'b1, m_act = 1'b0, m_rv = 1'b0, m_w = 1'b0, m_last = 1'b1;
  bit  m_rid = 1'b0, m_rerr = 1'b0, m_jm = 1'b0;
  int  m_gcyc = -100;
  logic [63:0] m_jd = '0, m_rd = '0;
  logic [79:0] m_jk = '0;
  int  hs_count = 0, load_count = 0, ready_count = 0, rv_count = 0;
  int  last_load_cyc = 0, last_ready_cyc = 0, rv_rise_cyc = 0;
  bit  prev_rv = 1'b0;
  int  grant_log[$];

  initial begin : compare
    int el;
    bit hs;
    forever begin
      @(negedge clk);
      cyc++;
      if (core_load && !rst) begin load_count++; last_load_cyc = cyc; end
      if (req0_ready || req1_ready) begin
        ready_count++;
        last_ready_cyc = cyc;
        grant_log.push_back(req1_ready ? 1 : 0);
      end
      if (rsp_valid) rv_count++;
      if (rsp_valid && !prev_rv) rv_rise_cyc = cyc;
      prev_rv = rsp_valid;
      if (rsp_valid && rsp_ready) hs_count++;
      if (rst) begin
        check("reset_ctl", 160'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, core_load, core_control}),
              160'(7'b0000010));
        check("reset_dat", 160'({rsp_dat, core_idat}), 160'(0));
        check("reset_key", 160'(core_key), 160'(0));
        m_free = 1'b1; m_act = 1'b0; m_rv = 1'b0; m_last = 1'b1; m_gcyc = -100;
        m_jd = '0; m_jk = '0; m_jm = 1'b0; m_rd = '0; m_rid = 1'b0; m_rerr = 1'b0;
      end else begin
        check("ready", 160'({req0_ready, req1_ready}), 160'({cyc == m_gcyc && !m_w, cyc == m_gcyc && m_w}));
        check("core_load", 160'(core_load), 160'(cyc == m_gcyc + 1));
        check("core_if", 160'({core_control, core_key, core_idat}), 160'({m_jm, m_jk, m_jd}));
        check("rsp", 160'({rsp_valid, rsp_id, rsp_err, rsp_dat}), 160'({m_rv, m_rid, m_rerr, m_rd}));
        hs = m_rv && rsp_ready;
        if (m_act && cyc >= m_gcyc + 2) begin
          el = cyc - (m_gcyc + 2);
          if (core_done && el >= DONE_MASK) begin
            m_rd = core_fn(m_jd, m_jk, m_jm); m_rerr = 1'b0; m_rid = m_w; m_rv = 1'b1; m_act = 1'b0;
          end else if (el == TIMEOUT - 1) begin
            m_rd = '0; m_rerr = 1'b1; m_rid = m_w; m_rv = 1'b1; m_act = 1'b0;
          end
        end
        if (cyc == m_gcyc) begin
          m_jd = m_w ? req1_dat : req0_dat;
          m_jk = m_w ? req1_key : req0_key;
          m_jm = m_w ? req1_mode : req0_mode;
        end
        if (m_free && (req0_valid || req1_valid)) begin
          m_w    = (req0_valid && req1_valid) ? !m_last : req1_valid;
          m_gcyc = cyc + 1;
          m_free = 1'b0;
          m_act  = 1'b1;
        end
        if (hs) begin m_rv = 1'b0; m_last = m_w; m_free = 1'b1; end
      end
    end
  end

  job_t q0[$], q1[$];

  initial begin : drv0
    bit acc;
    forever begin
      @(negedge clk);
      acc = req0_valid && req0_ready;
      @(posedge clk); #1;
      if (acc && q0.size() > 0) void'(q0.pop_front());
      if (!rst && q0.size() > 0) begin
        req0_valid = 1'b1; req0_dat = q0[0].d; req0_key = q0[0].k; req0_mode = q0[0].m;
      end else req0_valid = 1'b0;
    end
  end

  initial begin : drv1
    bit acc;
    forever begin
      @(negedge clk);
      acc = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (acc && q1.size() > 0) void'(q1.pop_front());
      if (!rst && q1.size() > 0) begin
        req1_valid = 1'b1; req1_dat = q1[0].d; req1_key = q1[0].k; req1_mode = q1[0].m;
      end else req1_valid = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_hs(input int target, input string name);
    int n = 0;
    while (hs_count < target && n < 400) begin @(negedge clk); #2; n++; end
    check(name, 160'(hs_count >= target), 160'(1));
  endtask

  task automatic wait_rv(input string name);
    int n = 0;
    while (!rsp_valid && n < 400) begin @(negedge clk); #2; n++; end
    check(name, 160'(rsp_valid), 160'(1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin : main
    int hsb, lc, rc, rvc, n;
    job_t jc;
    repeat (3) @(negedge clk);
    #2;
    check("rst_core_load", 160'(core_load), 160'(1));
    check("rst_rsp_valid", 160'(rsp_valid), 160'(0));
    release_reset();

    // single encrypt on requester 0
    step();
    q0.push_back('{DAT_A, KEY_A, 1'b0});
    wait_hs(1, "enc_hs");
    check("enc_dat", 160'(rsp_dat), 160'(RES_A));
    check("enc_id_err", 160'({rsp_id, rsp_err}), 160'(2'b00));
    check("enc_load_after_ready", 160'(last_load_cyc - last_ready_cyc), 160'(1));
    check("enc_one_load", 160'(load_count), 160'(1));

    // single decrypt on requester 1
    step();
    q1.push_back('{DAT_B, KEY_B, 1'b1});
    wait_hs(2, "dec_hs");
    check("dec_dat", 160'(rsp_dat), 160'(RES_B));
    check("dec_id_err", 160'({rsp_id, rsp_err}), 160'(2'b10));
    check("dec_control", 160'(core_control), 160'(1));

    // contention from reset: two jobs each, grants must alternate starting with 0
    step();
    rst = 1'b1;
    step(); step();
    release_reset();
    step();
    grant_log.delete();
    hsb = hs_count;
    q0.push_back('{64'h0123456789abcdef, 80'h11112222333344445555, 1'b0});
    q0.push_back('{64'hdeadbeefcafef00d, 80'h0f0e0d0c0b0a09080706, 1'b1});
    q1.push_back('{64'h1111111111111111, 80'h99999999999999999999, 1'b1});
    q1.push_back('{64'h8000000000000001, 80'hffffffffffffffffffff, 1'b0});
    wait_hs(hsb + 4, "rr_hs");
    check("rr_count", 160'(grant_log.size()), 160'(4));
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("rr_order", 160'(grant_log[i]), 160'(i % 2));

    // backpressure with a competing request pending
    step();
    rsp_ready = 1'b0;
    hsb = hs_count;
    jc = '{64'hfedcba9876543210, 80'h0123456789abcdef0123, 1'b0};
    q0.push_back(jc);
    q1.push_back('{64'h5555aaaa5555aaaa, 80'h0, 1'b0});
    wait_rv("bp_rv");
    lc = load_count;
    rc = ready_count;
    repeat (20) @(posedge clk);
    @(negedge clk); #2;
    check("bp_valid", 160'(rsp_valid), 160'(1));
    check("bp_dat", 160'(rsp_dat), 160'(64'hfedcba9876543210 ^ 64'h0123456789abcdef));
    check("bp_id", 160'(rsp_id), 160'(0));
    check("bp_no_load", 160'(load_count - lc), 160'(0));
    check("bp_no_ready", 160'(ready_count - rc), 160'(0));
    step();
    rsp_ready = 1'b1;
    wait_hs(hsb + 2, "bp_hs");
    check("bp_order", 160'({grant_log[grant_log.size()-2], grant_log[grant_log.size()-1]}), 160'({32'd0, 32'd1}));

    // timeout with a stale done pulse inside the mask window
    step();
    tie_done = 1'b1;
    hsb = hs_count;
    q0.push_back('{64'h0f0f0f0f0f0f0f0f, 80'h12345, 1'b0});
    wait_hs(hsb + 1, "to_hs");
    check("to_err_dat", 160'({rsp_err, rsp_dat}), 160'({1'b1, 64'h0}));
    check("to_latency", 160'(rv_rise_cyc - (last_load_cyc + 1)), 160'(TIMEOUT));
    step();
    tie_done = 1'b0;

    // reset ten cycles into an encrypt
    lc = load_count;
    q0.push_back('{DAT_A, KEY_A, 1'b0});
    n = 0;
    while (load_count == lc && n < 50) begin @(negedge clk); #2; n++; end
    check("mr_load_seen", 160'(load_count - lc), 160'(1));
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mr_ctl", 160'({req0_ready, req1_ready, rsp_valid, core_load}), 160'(4'b0001));
    check("mr_job", 160'({core_control, core_idat, core_key}), 160'(0));
    check("mr_rsp", 160'({rsp_id, rsp_err, rsp_dat}), 160'(0));
    step(); step();
    release_reset();
    rvc = rv_count;
    hsb = hs_count;
    repeat (60) step();
    check("mr_no_rsp", 160'(rv_count - rvc), 160'(0));
    q0.push_back('{DAT_A, KEY_A, 1'b0});
    wait_hs(hsb + 1, "mr_again_hs");
    check("mr_again_dat", 160'(rsp_dat), 160'(RES_A));
    check("mr_again_id_err", 160'({rsp_id, rsp_err}), 160'(2'b00));
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
